rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (wren/wraddr/wrdata/wrbyteen)

---
 rtl/rf_wb_arbiter_if.sv | 51 +++++
 rtl/rf_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
//  Module : rf_wb_arbiter_if
//  Brief  : Writeback request channels (ALU = A, LSU = B) and the
//           register-file write port shared between them.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 128,
  parameter int BW = 16
);
  // Requester A (ALU)
  logic          a_vld;
  logic          a_rdy;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [BW-1:0] a_byteen;

  // Requester B (load/store unit)
  logic          b_vld;
  logic          b_rdy;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [BW-1:0] b_byteen;

  // Registered register-file write port
  logic          wren;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic [BW-1:0] wrbyteen;

  // Arbiter side
  modport slave (
    input  a_vld, a_addr, a_data, a_byteen,
    input  b_vld, b_addr, b_data, b_byteen,
    output a_rdy, b_rdy,
    output wren, wraddr, wrdata, wrbyteen
  );

  // Requesters plus register-file side
  modport master (
    output a_vld, a_addr, a_data, a_byteen,
    output b_vld, b_addr, b_data, b_byteen,
    input  a_rdy, b_rdy,
    input  wren, wraddr, wrdata, wrbyteen
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
//  Module : rf_wb_arbiter
//  Brief  : Round-robin arbiter sharing the single register-file write port
//           between the ALU (A) and LSU (B) writeback paths, with a
//           pending-write scoreboard for decode hazard detection and a
//           sticky protocol-error flag.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 128,
  parameter int BW = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  rf_wb_arbiter_if.slave         wb,
  input  wire logic              issue_vld_i,
  input  wire logic [AW-1:0]     issue_addr_i,
  input  wire logic              chk1_en_i,
  input  wire logic [AW-1:0]     chk1_addr_i,
  input  wire logic              chk2_en_i,
  input  wire logic [AW-1:0]     chk2_addr_i,
  output logic                   hazard_o,
  output logic [(1<<AW)-1:0]     busy_o,
  output logic                   err_o
);

  localparam int NREG = 1 << AW;

  // Which requester won the most recent transfer; the other one is
  // favoured on the next contention.
  typedef enum logic [0:0] {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  grant_e          last_grant_q;
  grant_e          last_grant_d;

  logic            wren_q;
  logic [AW-1:0]   wraddr_q;
  logic [DW-1:0]   wrdata_q;
  logic [BW-1:0]   wrbyteen_q;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            err_q;
  logic            err_d;

  logic            w_gnt_a;
  logic            w_gnt_b;
  logic            w_xfer;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_data;
  logic [BW-1:0]   w_win_byteen;
  logic            w_issue_hits_clear;
  logic            w_err_issue;
  logic            w_err_xfer;

  // Round-robin grant; nothing is granted while reset is held so that
  // requesters cannot see a ready during reset.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_n) begin
      if (wb.a_vld && wb.b_vld) begin
        if (last_grant_q == GNT_B) begin
          w_gnt_a = 1'b1;
        end else begin
          w_gnt_b = 1'b1;
        end
      end else begin
        w_gnt_a = wb.a_vld;
        w_gnt_b = wb.b_vld;
      end
    end
  end

  assign w_xfer       = w_gnt_a | w_gnt_b;
  assign w_win_addr   = w_gnt_b ? wb.b_addr   : wb.a_addr;
  assign w_win_data   = w_gnt_b ? wb.b_data   : wb.a_data;
  assign w_win_byteen = w_gnt_b ? wb.b_byteen : wb.a_byteen;

  assign wb.a_rdy = w_gnt_a;
  assign wb.b_rdy = w_gnt_b;

  // Round-robin pointer advances only when a transfer actually happens.
  always_comb begin
    last_grant_d = last_grant_q;
    if (w_gnt_a) begin
      last_grant_d = GNT_A;
    end else if (w_gnt_b) begin
      last_grant_d = GNT_B;
    end
  end

  // Round-robin pointer register; reset favours A on first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Register the winning payload onto the write port; address, data and
  // byte enables hold their last value when no transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      wrbyteen_q <= '0;
    end else begin
      wren_q <= w_xfer;
      if (w_xfer) begin
        wraddr_q   <= w_win_addr;
        wrdata_q   <= w_win_data;
        wrbyteen_q <= w_win_byteen;
      end
    end
  end

  assign wb.wren     = wren_q;
  assign wb.wraddr   = wraddr_q;
  assign wb.wrdata   = wrdata_q;
  assign wb.wrbyteen = wrbyteen_q;

  // Scoreboard next state: clear on transfer, then set on issue so a
  // newer in-flight instruction to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (w_xfer) begin
      busy_d[w_win_addr] = 1'b0;
    end
    if (issue_vld_i) begin
      busy_d[issue_addr_i] = 1'b1;
    end
  end

  // An issue to a register that is being written back this very cycle is
  // legitimate: the old write retires as the new one becomes pending.
  assign w_issue_hits_clear = w_xfer && (w_win_addr == issue_addr_i);
  assign w_err_issue        = issue_vld_i && busy_q[issue_addr_i] && !w_issue_hits_clear;
  assign w_err_xfer         = w_xfer && !busy_q[w_win_addr];

  // Sticky error accumulates any protocol violation.
  always_comb begin
    err_d = err_q | w_err_issue | w_err_xfer;
  end

  // Scoreboard and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Hazard looks at the current scoreboard only; a register cleared at an
  // edge is not busy from the following cycle.
  always_comb begin
    hazard_o = (chk1_en_i   && busy_q[chk1_addr_i])
             | (chk2_en_i   && busy_q[chk2_addr_i])
             | (issue_vld_i && busy_q[issue_addr_i]);
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 128;
  localparam int BW   = 16;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_vld = 1'b0;
  logic [AW-1:0]   issue_addr = '0;
  logic            chk1_en = 1'b0;
  logic [AW-1:0]   chk1_addr = '0;
  logic            chk2_en = 1'b0;
  logic [AW-1:0]   chk2_addr = '0;
  logic            hazard;
  logic [NREG-1:0] busy;
  logic            err;

  rf_wb_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

  rf_wb_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (bus.slave),
    .issue_vld_i  (issue_vld),
    .issue_addr_i (issue_addr),
    .chk1_en_i    (chk1_en),
    .chk1_addr_i  (chk1_addr),
    .chk2_en_i    (chk2_en),
    .chk2_addr_i  (chk2_addr),
    .hazard_o     (hazard),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: set of pending registers, who was served last,
  // sticky error and the expected write-port contents.
  logic [NREG-1:0] m_busy;
  int              m_last;      // 0 = A served last, 1 = B served last
  bit              m_err;
  bit              m_wren;
  logic [AW-1:0]   m_wraddr;
  logic [DW-1:0]   m_wrdata;
  logic [BW-1:0]   m_wrbyteen;

  int   g_now;                  // model's winner of the last cycle (-1 none)
  logic obs_a_rdy, obs_b_rdy, obs_hazard;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = '0;
    m_last     = 1;
    m_err      = 1'b0;
    m_wren     = 1'b0;
    m_wraddr   = '0;
    m_wrdata   = '0;
    m_wrbyteen = '0;
  endtask

  // Fair sharing: if both ask, the one not served last goes.
  function automatic int model_grant();
    if (bus.a_vld && bus.b_vld) return (m_last == 1) ? 0 : 1;
    if (bus.a_vld) return 0;
    if (bus.b_vld) return 1;
    return -1;
  endfunction

  function automatic logic model_hazard();
    return (chk1_en && m_busy[chk1_addr]) || (chk2_en && m_busy[chk2_addr])
        || (issue_vld && m_busy[issue_addr]);
  endfunction

  // One clock cycle: inputs are set at posedge+1 by the caller; combinational
  // outputs are checked at posedge+3, registered outputs at next posedge+1.
  task automatic cyc();
    int            g;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [BW-1:0] wbe;
    wa = '0; wd = '0; wbe = '0;
    #2;
    g = model_grant();
    g_now      = g;
    obs_a_rdy  = bus.a_rdy;
    obs_b_rdy  = bus.b_rdy;
    obs_hazard = hazard;
    chk("a_rdy",  bus.a_rdy, (g == 0));
    chk("b_rdy",  bus.b_rdy, (g == 1));
    chk("hazard", hazard, model_hazard());
    if (g == 0) begin
      wa = bus.a_addr; wd = bus.a_data; wbe = bus.a_byteen;
    end else if (g == 1) begin
      wa = bus.b_addr; wd = bus.b_data; wbe = bus.b_byteen;
    end
    if (issue_vld && m_busy[issue_addr] && !(g >= 0 && wa == issue_addr)) m_err = 1'b1;
    if (g >= 0 && !m_busy[wa]) m_err = 1'b1;
    if (g >= 0) m_busy[wa] = 1'b0;
    if (issue_vld) m_busy[issue_addr] = 1'b1;
    m_wren = (g >= 0);
    if (g >= 0) begin
      m_wraddr = wa; m_wrdata = wd; m_wrbyteen = wbe; m_last = g;
    end
    @(posedge clk); #1;
    chk("wren",     bus.wren,     m_wren);
    chk("wraddr",   bus.wraddr,   m_wraddr);
    chk("wrdata",   bus.wrdata,   m_wrdata);
    chk("wrbyteen", bus.wrbyteen, m_wrbyteen);
    chk("busy",     busy,         m_busy);
    chk("err",      err,          m_err);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wren",  bus.wren,  1'b0);
    chk("rst_busy",  busy,      '0);
    chk("rst_err",   err,       1'b0);
    chk("rst_a_rdy", bus.a_rdy, 1'b0);
    chk("rst_b_rdy", bus.b_rdy, 1'b0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.a_vld = 1'b0; bus.b_vld = 1'b0;
    issue_vld = 1'b0; chk1_en = 1'b0; chk2_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_write_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, NREG-1));
    for (int k = 0; k < 8; k++) begin
      if (m_busy[a]) return a;
      a = AW'($urandom_range(0, NREG-1));
    end
    return a;
  endfunction

  initial begin
    bus.a_vld = 1'b1; bus.a_addr = '0; bus.a_data = '0; bus.a_byteen = '0;
    bus.b_vld = 1'b1; bus.b_addr = '0; bus.b_data = '0; bus.b_byteen = '0;
    model_reset();
    g_now = -1;

    // Reset held with both requesters valid
    #3;
    chk("t1_a_rdy", bus.a_rdy, 1'b0);
    chk("t1_b_rdy", bus.b_rdy, 1'b0);
    chk("t1_wren",  bus.wren,  1'b0);
    chk("t1_busy",  busy,      '0);
    chk("t1_err",   err,       1'b0);
    chk("t1_wraddr", bus.wraddr, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();

    // Single ALU write to r5
    issue_vld = 1'b1; issue_addr = 5;
    cyc();
    chk("t2_busy5_set", busy[5], 1'b1);
    issue_vld = 1'b0;
    bus.a_vld = 1'b1; bus.a_addr = 5;
    bus.a_data = {4{32'h11111111}}; bus.a_byteen = 16'hFFFF;
    cyc();
    chk("t2_a_rdy",  obs_a_rdy, 1'b1);
    chk("t2_wren",   bus.wren, 1'b1);
    chk("t2_wraddr", bus.wraddr, 5);
    chk("t2_busy5",  busy[5], 1'b0);
    bus.a_vld = 1'b0;
    cyc();
    chk("t2_wren_drop", bus.wren, 1'b0);

    // Contention A,B,A,B after reset
    apply_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_vld = 1'b1; issue_addr = AW'(r);
      cyc();
    end
    issue_vld = 1'b0;
    bus.a_vld = 1'b1; bus.a_addr = 1; bus.a_data = {4{32'hA1A1A1A1}}; bus.a_byteen = 16'h00FF;
    bus.b_vld = 1'b1; bus.b_addr = 2; bus.b_data = {4{32'hB2B2B2B2}}; bus.b_byteen = 16'hFF00;
    cyc();
    chk("t3_g1_a", obs_a_rdy, 1'b1);
    bus.a_addr = 3; bus.a_data = {4{32'hA3A3A3A3}}; bus.a_byteen = 16'h0000;
    cyc();
    chk("t3_g2_b", obs_b_rdy, 1'b1);
    bus.b_addr = 4; bus.b_data = {4{32'hB4B4B4B4}}; bus.b_byteen = 16'h0F0F;
    cyc();
    chk("t3_g3_a", obs_a_rdy, 1'b1);
    bus.a_vld = 1'b0;
    cyc();
    chk("t3_g4_b", obs_b_rdy, 1'b1);
    chk("t3_wr4",  bus.wraddr, 4);
    idle_inputs();
    cyc();

    // Hazard on r7 until the cycle after B writes it
    issue_vld = 1'b1; issue_addr = 7;
    cyc();
    issue_vld = 1'b0;
    chk1_en = 1'b1; chk1_addr = 7; chk2_en = 1'b1; chk2_addr = 8;
    cyc();
    chk("t4_haz_pend", obs_hazard, 1'b1);
    bus.b_vld = 1'b1; bus.b_addr = 7; bus.b_data = {4{32'h77777777}}; bus.b_byteen = 16'hFFFF;
    cyc();
    chk("t4_haz_wrcyc", obs_hazard, 1'b1);
    bus.b_vld = 1'b0;
    cyc();
    chk("t4_haz_clear", obs_hazard, 1'b0);
    chk1_en = 1'b0;
    cyc();
    chk("t4_chk2_only", obs_hazard, 1'b0);
    idle_inputs();

    // Same-cycle set and clear of r3, r3 busy beforehand
    issue_vld = 1'b1; issue_addr = 3;
    cyc();
    bus.a_vld = 1'b1; bus.a_addr = 3; bus.a_data = {4{32'h33333333}}; bus.a_byteen = 16'h1234;
    cyc();
    chk("t5a_busy3", busy[3], 1'b1);
    chk("t5a_err",   err, 1'b0);
    idle_inputs();

    // Same again with r3 not busy beforehand
    apply_reset();
    issue_vld = 1'b1; issue_addr = 3;
    bus.a_vld = 1'b1; bus.a_addr = 3;
    cyc();
    chk("t5b_busy3", busy[3], 1'b1);
    chk("t5b_err",   err, 1'b1);
    idle_inputs();

    // Reset in the middle of a contended burst
    apply_reset();
    issue_vld = 1'b1; issue_addr = 10;
    cyc();
    issue_addr = 11;
    cyc();
    issue_vld = 1'b0;
    bus.a_vld = 1'b1; bus.a_addr = 10; bus.a_data = {4{32'hAAAA0010}};
    bus.b_vld = 1'b1; bus.b_addr = 11; bus.b_data = {4{32'hBBBB0011}};
    cyc();
    chk("t6_pre_wren", bus.wren, 1'b1);
    apply_reset();
    cyc();
    chk("t6_first_a", obs_a_rdy, 1'b1);
    idle_inputs();

    // Randomized traffic against the model
    apply_reset();
    g_now = -1;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.a_vld && g_now != 0)) begin
        bus.a_vld = ($urandom_range(0, 3) != 0);
        bus.a_addr = pick_write_addr();
        bus.a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.a_byteen = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
      end
      if (!(bus.b_vld && g_now != 1)) begin
        bus.b_vld = ($urandom_range(0, 2) != 0);
        bus.b_addr = pick_write_addr();
        bus.b_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.b_byteen = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
      end
      issue_vld  = ($urandom_range(0, 1) == 0);
      issue_addr = AW'($urandom_range(0, NREG-1));
      chk1_en    = ($urandom_range(0, 1) == 0);
      chk1_addr  = AW'($urandom_range(0, NREG-1));
      chk2_en    = ($urandom_range(0, 1) == 0);
      chk2_addr  = AW'($urandom_range(0, NREG-1));
      if (i == 200) begin
        apply_reset();
        g_now = -1;
      end
      cyc();
    end
    idle_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
